// File: rtl/imm_encoder.sv
// Packs a signed immediate into the I/S/B immediate fields of an instruction
// word and buffers the result in a 2-entry valid/ready FIFO.
module imm_encoder #(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N/2-1:0]   in_base,
  input  logic [N-1:0]     in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N/2-1:0]   out_instr,
  output logic             out_ovf,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int IW = N / 2;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          ovf;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t        state, state_nxt;
  entry_t        mem [2];
  logic          wptr, rptr;
  logic          push, pop;
  logic [IW-1:0] enc;
  logic [11:0]   imm12;
  logic          ovf_w;

  // Field placement assumes the 32-bit base ISA layout.
  always_comb begin
    imm12 = in_imm[11:0];
    enc   = in_base;
    case (in_base[6:5])
      2'b10: enc[31:20] = imm12;
      2'b11: begin
        enc[31:25] = imm12[11:5];
        enc[11:7]  = imm12[4:0];
      end
      default: begin
        enc[31]    = imm12[11];
        enc[7]     = imm12[10];
        enc[30:25] = imm12[9:4];
        enc[11:8]  = imm12[3:0];
      end
    endcase
  end

  // Fits in 12 bits only if everything from bit 11 up is a sign copy.
  assign ovf_w = ~((&in_imm[N-1:11]) | ~(|in_imm[N-1:11]));

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_instr = mem[rptr].instr;
  assign out_ovf   = mem[rptr].ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      enc_count <= '0;
      ovf_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{instr: enc, ovf: ovf_w};
        wptr      <= ~wptr;
        enc_count <= enc_count + CNT_W'(1);
        if (ovf_w && ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
      end
      if (pop) rptr <= ~rptr;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: spec vectors, FIFO corner sequences, and a random
// run against a decode-based scoreboard.
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_base;
  logic [63:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_ovf;
  logic [15:0] enc_count, ovf_count;

  imm_encoder #(.N(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_ovf(out_ovf),
    .enc_count(enc_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [63:0] imm;
    logic [31:0] exp;
    logic        eo;
  } vec_t;

  typedef struct {
    logic [31:0] base;
    logic [63:0] imm;
  } req_t;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] enc_m = '0;
  logic [15:0] ovf_m = '0;
  req_t        q[$];
  vec_t        tbl[8];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: what the immediate generator recovers from a word.
  function automatic logic [63:0] dec(logic [31:0] w);
    logic [11:0] t;
    case (w[6:5])
      2'b10:   t = w[31:20];
      2'b11:   t = {w[31:25], w[11:7]};
      default: t = {w[31], w[7], w[30:25], w[11:8]};
    endcase
    return {{52{t[11]}}, t};
  endfunction

  function automatic logic [63:0] sext12(logic [63:0] v);
    return {{52{v[11]}}, v[11:0]};
  endfunction

  function automatic logic ovf_ref(logic [63:0] v);
    longint s;
    s = longint'(v);
    return (s < -2048) || (s > 2047);
  endfunction

  function automatic logic [31:0] fmask(logic [31:0] b);
    return (b[6:5] == 2'b10) ? 32'hFFF0_0000 : 32'hFE00_0F80;
  endfunction

  task automatic model_push(logic [31:0] b, logic [63:0] im);
    enc_m++;
    if (ovf_ref(im) && ovf_m != 16'hFFFF) ovf_m++;
  endtask

  // Single word through an empty FIFO; starts and ends at a negedge.
  task automatic one_word(vec_t v, string tag);
    in_valid = 1'b1; in_base = v.base; in_imm = v.imm; out_ready = 1'b0;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_nobypass"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(v.base, v.imm);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(out_instr), 64'(v.exp));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(v.eo));
    chk({tag, "_dec"}, dec(out_instr), sext12(v.imm));
    chk({tag, "_enc"}, 64'(enc_count), 64'(enc_m));
    chk({tag, "_ovfc"}, 64'(ovf_count), 64'(ovf_m));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  // One cycle against the queue scoreboard; starts and ends at a negedge.
  task automatic step(logic v, logic [31:0] b, logic [63:0] im, logic ordy);
    logic push, pop;
    req_t e;
    in_valid = v; in_base = b; in_imm = im; out_ready = ordy;
    #1;
    chk("occ_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("occ_ready", 64'(in_ready), 64'(q.size() != 2));
    chk("enc_cnt", 64'(enc_count), 64'(enc_m));
    chk("ovf_cnt", 64'(ovf_count), 64'(ovf_m));
    push = v && (q.size() != 2);
    pop  = ordy && (q.size() != 0);
    if (pop) begin
      e = q[0];
      chk("sb_dec", dec(out_instr), sext12(e.imm));
      chk("sb_base", 64'(out_instr & ~fmask(e.base)), 64'(e.base & ~fmask(e.base)));
      chk("sb_ovf", 64'(out_ovf), 64'(ovf_ref(e.imm)));
    end
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back('{base: b, imm: im});
      model_push(b, im);
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_imm();
    logic [63:0] edges [4];
    edges[0] = 64'd2047;
    edges[1] = 64'd2048;
    edges[2] = 64'hFFFF_FFFF_FFFF_F800;
    edges[3] = 64'hFFFF_FFFF_FFFF_F7FF;
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'(longint'($urandom_range(0, 4095)) - 64'sd2048);
      2:       return edges[$urandom_range(0, 3)];
      default: return 64'(longint'($urandom_range(0, 70000)) - 64'sd35000);
    endcase
  endfunction

  initial begin
    tbl[0] = '{32'h0000_0043, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF0_0043, 1'b0};
    tbl[1] = '{32'h0000_0063, 64'h0000_0000_0000_07FF, 32'h7E00_0FE3, 1'b0};
    tbl[2] = '{32'hFFFF_FFE3, 64'h0000_0000_0000_07FF, 32'h7FFF_FFE3, 1'b0};
    tbl[3] = '{32'h0000_0003, 64'hFFFF_FFFF_FFFF_F800, 32'h8000_0003, 1'b0};
    tbl[4] = '{32'h0000_0043, 64'h0000_0000_0000_0800, 32'h8000_0043, 1'b1};
    tbl[5] = '{32'h0000_0023, 64'h0000_0000_0000_07FF, 32'h7E00_0FA3, 1'b0};
    tbl[6] = '{32'h0000_0043, 64'hFFFF_FFFF_FFFF_F7FF, 32'h7FF0_0043, 1'b1};
    tbl[7] = '{32'hFFFF_FFC3, 64'h0000_0000_0000_0000, 32'h000F_FFC3, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_base = '0; in_imm = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_enc", 64'(enc_count), 64'd0);
    chk("rst_ovfc", 64'(ovf_count), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) one_word(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: third word waits for FULL to drain to ONE.
    in_valid = 1'b1; in_base = 32'h0000_0043; in_imm = 64'd1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_imm = 64'd2; #1;
    chk("bp_rdy1", 64'(in_ready), 64'd1);
    chk("bp_head1", 64'(out_instr), 64'h0010_0043);
    @(posedge clk); @(negedge clk);
    in_imm = 64'd3; #1;
    chk("bp_full", 64'(in_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("bp_hold", 64'(out_instr), 64'h0010_0043);
    out_ready = 1'b1; #1;
    chk("bp_nocomb", 64'(in_ready), 64'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("bp_one_rdy", 64'(in_ready), 64'd1);
    chk("bp_head2", 64'(out_instr), 64'h0020_0043);
    chk("bp_enc2", 64'(enc_count), 64'(enc_m + 16'd2));
    @(posedge clk); @(negedge clk); #1;
    in_valid = 1'b0;
    chk("bp_pushpop_vld", 64'(out_valid), 64'd1);
    chk("bp_head3", 64'(out_instr), 64'h0030_0043);
    chk("bp_enc3", 64'(enc_count), 64'(enc_m + 16'd3));
    @(posedge clk); @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    enc_m = enc_m + 16'd3;

    // Reset while FULL, asserted between edges.
    in_valid = 1'b1; in_base = 32'h0000_0063; in_imm = 64'h900;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mr_vld", 64'(out_valid), 64'd0);
    chk("mr_rdy", 64'(in_ready), 64'd1);
    chk("mr_enc", 64'(enc_count), 64'd0);
    chk("mr_ovfc", 64'(ovf_count), 64'd0);
    chk("mr_instr", 64'(out_instr), 64'd0);
    enc_m = '0; ovf_m = '0;
    @(negedge clk);
    rst = 1'b0;
    one_word(tbl[1], "mr_after");

    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), $urandom, rand_imm(), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 4 && q.size() != 0; i++) step(1'b0, '0, '0, 1'b1);

    // Saturate ovf_count; enc_count wraps along the way.
    for (int i = 0; i < 70000 && ovf_m != 16'hFFFF; i++)
      step(1'b1, 32'h0000_0043, 64'h0000_0001_0000_0000, 1'b1);
    for (int i = 0; i < 4 && q.size() != 0; i++) step(1'b0, '0, '0, 1'b1);
    chk("sat_reached", 64'(ovf_count), 64'hFFFF);
    step(1'b1, 32'h0000_0043, 64'h800, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("sat_hold", 64'(ovf_count), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
